// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared seven-segment patterns and controller state encoding.
package hex_display_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, COMMIT} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Active-low gfedcba patterns for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/hex_digit_decoder.sv
// hex_digit_decoder: combinational nibble to seven-segment pattern with blanking and polarity select.
module hex_digit_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       active_low,
  output logic [6:0] seg
);
  logic [6:0] raw;
  always_comb begin
    raw = blank ? SEG_BLANK : SEG7[nibble];
    seg = active_low ? raw : ~raw;
  end
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: multi-digit hex display with serial shared decode, tear-free commit, leading-zero blanking and blinking.
// Define HEX_DISPLAY_SCROLL_EN to add the scroll_en input and rotating digit mapping.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    lzb_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`ifdef HEX_DISPLAY_SCROLL_EN
  input  logic                    scroll_en,
`endif
  output logic [7*NUM_DIGITS-1:0] hex_out
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic POL = ACTIVE_LOW != 0;
  localparam logic [6:0] BLANK = POL ? SEG_BLANK : ~SEG_BLANK;

  state_t state, state_nx;
  logic [IW-1:0] idx, offset;
  logic [4*NUM_DIGITS-1:0] val;
  logic lzb, zero_run, phase, wrap, nib_zero, blank_dig;
  logic [6:0] shadow [NUM_DIGITS];
  logic [6:0] display [NUM_DIGITS];
  logic [CW-1:0] cnt;
  logic [3:0] nib;
  logic [6:0] seg;

  assign nib = val[4*idx +: 4];
  assign nib_zero = nib == 4'h0;
  // Blank only while every higher digit was zero; digit 0 always shows.
  assign blank_dig = lzb && zero_run && nib_zero && idx != '0;
  assign wrap = cnt == CW'(BLINK_DIV - 1);

  hex_digit_decoder u_dec (
    .nibble(nib),
    .blank(blank_dig),
    .active_low(POL),
    .seg(seg)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    load_ready = state == IDLE;
    state_nx = state == IDLE ? (load_valid ? DECODE : IDLE)
             : state == DECODE ? (idx == '0 ? COMMIT : DECODE)
             : IDLE;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx <= '0;
      val <= '0;
      lzb <= 1'b0;
      zero_run <= 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow[k] <= BLANK;
        display[k] <= BLANK;
      end
    end else begin
      if (state == IDLE && load_valid) begin
        val <= load_value;
        lzb <= lzb_en;
        idx <= IW'(NUM_DIGITS - 1);
        zero_run <= 1'b1;
      end
      if (state == DECODE) begin
        shadow[idx] <= seg;
        zero_run <= zero_run && nib_zero;
        idx <= idx - 1'b1;
      end
      if (state == COMMIT)
        for (int k = 0; k < NUM_DIGITS; k++) display[k] <= shadow[k];
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      phase <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      phase <= phase ^ wrap;
    end

`ifdef HEX_DISPLAY_SCROLL_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) offset <= '0;
    else if (state == COMMIT) offset <= '0;
    else if (scroll_en && wrap) offset <= offset == IW'(NUM_DIGITS - 1) ? '0 : offset + 1'b1;
`else
  assign offset = '0;
`endif

  // Blink masks physical positions, after any rotation.
  always_comb begin
    hex_out = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      hex_out[7*i +: 7] = (blink_mask[i] && phase) ? BLANK
                        : display[(i + int'(offset)) % NUM_DIGITS];
  end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed checks of load latency, blanking, handshake, blink, abort and optional scroll.
module tb_hex_display_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, load_valid = 1'b0, lzb_en = 1'b0, load_ready;
  logic [23:0] load_value = '0;
  logic [5:0] blink_mask = '0;
  logic [41:0] hex_out, cur;
`ifdef HEX_DISPLAY_SCROLL_EN
  logic scroll_en = 1'b0;
  int r0;
  logic found;
`endif
  int passed = 0, failed = 0, total = 0, n;
  logic [6:0] v, other;

  localparam logic [41:0] BLANK6 = {6{7'h7F}};
  localparam logic [41:0] PAT_A = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] PAT_B = {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  localparam logic [41:0] PAT_F0 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40};

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_value(load_value),
    .lzb_en(lzb_en),
    .blink_mask(blink_mask),
`ifdef HEX_DISPLAY_SCROLL_EN
    .scroll_en(scroll_en),
`endif
    .hex_out(hex_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_commit(input string tag, input logic [41:0] during, input logic [41:0] fin);
    int c = 0;
    while (!load_ready && c < 20) begin
      chk({tag, "_tearfree"}, hex_out, during);
      c++;
      step();
    end
    chk({tag, "_busy"}, c, 7);
    chk({tag, "_final"}, hex_out, fin);
  endtask

  task automatic do_load(input string tag, input logic [23:0] val, input logic lzb, input logic [41:0] exp);
    load_value = val;
    lzb_en = lzb;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    wait_commit(tag, cur, exp);
    cur = exp;
  endtask

  function automatic logic [41:0] rot(input logic [41:0] x, input int r);
    for (int i = 0; i < 6; i++) rot[7*i +: 7] = x[7*((i + r) % 6) +: 7];
  endfunction

  initial begin
    cur = BLANK6;
    repeat (3) step();
    chk("reset_blank", hex_out, BLANK6);
    chk("reset_ready", load_ready, 1'b1);
    reset_n = 1'b1;
    step();
    do_load("load_1a5", 24'h0001A5, 1'b0, {7'h40, 7'h40, 7'h40, 7'h79, 7'h08, 7'h12});
    do_load("lzb_f0", 24'h0000F0, 1'b1, PAT_F0);
    do_load("lzb_zero", 24'h000000, 1'b1, {{5{7'h7F}}, 7'h40});
    load_value = 24'h123456;
    lzb_en = 1'b0;
    load_valid = 1'b1;
    step();
    load_value = 24'h654321;
    wait_commit("hs_first", cur, PAT_A);
    step();
    load_valid = 1'b0;
    wait_commit("hs_second", PAT_A, PAT_B);
    cur = PAT_B;
    blink_mask = 6'b000001;
    #1;
    n = 0;
    v = hex_out[6:0];
    while (hex_out[6:0] === v && n < 10) begin
      step();
      n++;
    end
    chk("blink_sync", n < 10, 1'b1);
    v = hex_out[6:0];
    chk("blink_value", v === 7'h79 || v === 7'h7F, 1'b1);
    other = v === 7'h7F ? 7'h79 : 7'h7F;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("blink_d0", hex_out[6:0], k < 4 || k == 8 ? v : other);
      chk("blink_steady", hex_out[41:7], PAT_B[41:7]);
    end
    n = 0;
    while (hex_out[6:0] !== 7'h7F && n < 10) begin
      step();
      n++;
    end
    chk("blink_find_off", hex_out[6:0], 7'h7F);
    blink_mask = '0;
    #1;
    chk("blink_clear", hex_out[6:0], 7'h79);
    step();
    load_value = 24'h0001A5;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("abort_blank", hex_out, BLANK6);
    chk("abort_ready", load_ready, 1'b1);
    step();
    reset_n = 1'b1;
    repeat (10) step();
    chk("abort_no_commit", hex_out, BLANK6);
    chk("abort_idle", load_ready, 1'b1);
    cur = BLANK6;
    do_load("post_abort", 24'h0000F0, 1'b1, PAT_F0);
`ifdef HEX_DISPLAY_SCROLL_EN
    do_load("scr_load", 24'h123456, 1'b0, PAT_A);
    scroll_en = 1'b1;
    n = 0;
    while (hex_out === PAT_A && n < 40) begin
      step();
      n++;
    end
    found = 1'b0;
    r0 = 0;
    for (int r = 0; r < 6; r++)
      if (!found && hex_out === rot(PAT_A, r)) begin
        found = 1'b1;
        r0 = r;
      end
    chk("scroll_started", found && r0 != 0, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      step();
      chk("scroll_rot", hex_out, rot(PAT_A, (r0 + k / 4) % 6));
    end
    scroll_en = 1'b0;
    load_value = 24'h654321;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    n = 0;
    while (!load_ready && n < 20) begin
      step();
      n++;
    end
    chk("scroll_reset_offset", hex_out, PAT_B);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
